// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the radix-2 SDF FFT stage sequencer.
// No ports. Provides default frame geometry, datapath widths and the
// stage state type used by fft_stage_seq.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N_POINTS = 512;
    localparam int FFT_LANES    = 16;
    localparam int FFT_BEATS    = FFT_N_POINTS / FFT_LANES;
    localparam int FFT_DELAY    = 4;
    localparam int FFT_PIPE_LAT = 2;
    localparam int FFT_TW_AW    = $clog2(FFT_N_POINTS);

    // Datapath widths, shared with the stage datapath modules.
    localparam int FFT_DATA_W   = 16;
    localparam int FFT_TWF_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } stage_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// -----------------------------------------------------------------------------
// valid_delay_line
// Fixed-depth 1-bit shift register with asynchronous clear, used to align
// stage-level markers with the butterfly + CBFP register pipeline.
// Ports:
//   clk   in   clock
//   rstn  in   async active-low reset, clears every stage
//   i_d   in   marker entering the pipe
//   o_q   out  marker delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | DEPTH'(i_d);
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_seq.sv
// -----------------------------------------------------------------------------
// fft_stage_seq
// Sequencer for one 16-lane radix-2 SDF FFT stage. Counts accepted beats per
// frame and drives the shift register, feedback mux, butterfly, twiddle ROM
// and output-valid/frame markers.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a frame
//   RUN   | accepting beats 0..BEATS-1, fill / combine alternating
//   FLUSH | DELAY cycles draining stored differences, input held off
//
// Ports:
//   clk          in   clock
//   rstn         in   async active-low reset
//   din_valid    in   upstream beat valid
//   din_ready    out  beat accepted when din_valid & din_ready
//   sr_shift_en  out  advance shift register
//   sel_fb       out  shift-register input = stored difference path
//   bfly_en      out  butterfly combines shift-reg output with input
//   twf_addr     out  twiddle ROM base address
//   twf_valid    out  twiddle product valid (ROM output aligned)
//   valid_out    out  stage output beat valid
//   frame_start  out  first accepted beat of a frame
//   frame_done   out  last output beat of a frame
// -----------------------------------------------------------------------------
module fft_stage_seq
    import fft_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int LANES    = FFT_LANES,
    parameter int DELAY    = FFT_DELAY,
    parameter int PIPE_LAT = FFT_PIPE_LAT,
    parameter int TW_AW    = FFT_TW_AW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sr_shift_en,
    output logic             sel_fb,
    output logic             bfly_en,
    output logic [TW_AW-1:0] twf_addr,
    output logic             twf_valid,
    output logic             valid_out,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int BEATS  = N_POINTS / LANES;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int PH_BIT = $clog2(DELAY);

    stage_state_e     r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_din_ready;
    logic [TW_AW-1:0] r_twf_addr;
    logic             r_twf_valid;

    logic w_accept;
    logic w_phase;
    logic w_flush;
    logic w_last_in;
    logic w_flush_end;
    logic w_out_beat;
    logic w_done_beat;

    assign w_accept    = din_valid & r_din_ready;
    assign w_phase     = r_beat_cnt[PH_BIT];
    assign w_flush     = (r_state == FLUSH);
    assign w_last_in   = w_accept & (r_beat_cnt == CNT_W'(BEATS - 1));
    // In FLUSH the beat counter is reused to time the drain.
    assign w_flush_end = w_flush & (r_beat_cnt == CNT_W'(DELAY - 1));

    assign din_ready   = r_din_ready;
    assign sr_shift_en = w_accept | w_flush;
    assign sel_fb      = (w_accept & w_phase) | w_flush;
    assign bfly_en     = w_accept & w_phase;
    assign frame_start = w_accept & (r_state == IDLE);
    assign twf_addr    = r_twf_addr;
    assign twf_valid   = r_twf_valid;

    // An output beat leaves the stage for every sum (combine beat), every
    // drained difference (flush) and every difference pushed out of the
    // shift register by a fill beat once the first block has been combined.
    assign w_out_beat  = bfly_en | w_flush |
                         (w_accept & ~w_phase &
                          ({1'b0, r_beat_cnt} >= (CNT_W + 1)'(2 * DELAY)));
    assign w_done_beat = w_out_beat & (r_out_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_din_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_din_ready <= 1'b1;
                    if (w_accept) begin
                        r_state    <= RUN;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_din_ready <= ~w_last_in;
                    if (w_last_in) begin
                        r_state    <= FLUSH;
                        r_beat_cnt <= '0;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (w_flush_end) begin
                        r_state     <= IDLE;
                        r_beat_cnt  <= '0;
                        r_din_ready <= 1'b1;
                    end else begin
                        r_beat_cnt  <= r_beat_cnt + 1'b1;
                        r_din_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_beat_cnt  <= '0;
                    r_din_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_twf_addr  <= '0;
            r_twf_valid <= 1'b0;
            r_out_cnt   <= '0;
        end else begin
            r_twf_valid <= bfly_en | w_flush;
            // Address is consumed in the bfly/flush cycle, then stepped; it is
            // parked at 0 between frames so frame_start always sees 0.
            if (frame_start || w_flush_end) begin
                r_twf_addr <= '0;
            end else if (bfly_en || w_flush) begin
                r_twf_addr <= r_twf_addr + TW_AW'(LANES);
            end
            if (w_out_beat) begin
                r_out_cnt <= w_done_beat ? '0 : r_out_cnt + 1'b1;
            end
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_dly (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (w_out_beat),
        .o_q  (valid_out)
    );

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_done_dly (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (w_done_beat),
        .o_q  (frame_done)
    );

endmodule
